// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the round-robin / explicit-select stream mux.
package stream_mux_pkg;

    // Grant state: IDLE picks a new channel, LOCKED holds it until the last beat.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Selection modes for the MODE parameter.
    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Increment a channel index with wrap from n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_picker.sv
// Round-robin picker: finds the first asserted request starting at ptr and
// wrapping modulo CHANNELS. Purely combinational.
module rr_picker #(
    parameter int CHANNELS = 4,
    parameter int IDXW     = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDXW-1:0]     ptr,
    output logic                found,
    output logic [IDXW-1:0]     idx
);

    // Doubling the request vector lets a plain right shift act as a rotate,
    // which also works when CHANNELS is not a power of two.
    logic [2*CHANNELS-1:0] req_dbl;
    logic [2*CHANNELS-1:0] req_shift;
    logic [CHANNELS-1:0]   req_rot;
    logic [IDXW-1:0]       offset;
    logic [IDXW:0]         sum;

    assign req_dbl   = {req, req};
    assign req_shift = req_dbl >> ptr;
    assign req_rot   = req_shift[CHANNELS-1:0];

    // Priority-encode the rotated vector: lowest offset from ptr wins.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found  = 1'b1;
                offset = IDXW'(k);
            end
        end
    end

    // Map the rotated offset back to an absolute channel index.
    always_comb begin
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (IDXW+1)'(CHANNELS)) begin
            idx = IDXW'(sum - (IDXW+1)'(CHANNELS));
        end else begin
            idx = sum[IDXW-1:0];
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel packet multiplexer with valid/ready handshake, registered output
// and a per-packet grant lock. Channel choice is either an explicit sel input
// or round-robin among valid channels.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SELW-1:0]           sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [SELW-1:0]           out_chan,
    input  logic                      out_ready,
    output logic                      busy
);

    // Registered state and its next-state values.
    state_e            state_q,     state_d;
    logic [SELW-1:0]   grant_q,     grant_d;
    logic [SELW-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q,  out_last_d;
    logic [SELW-1:0]   out_chan_q,  out_chan_d;
    logic              busy_q,      busy_d;

    // Per-channel views and selection helpers.
    logic [WIDTH-1:0]    chan_data [CHANNELS];
    logic [CHANNELS-1:0] sel_hit_vec;
    logic [CHANNELS-1:0] cand_oh;
    logic                cand_valid;
    logic [SELW-1:0]     cand_idx;
    logic                pick_found;
    logic [SELW-1:0]     pick_idx;
    logic                can_load;
    logic                accept;
    logic [WIDTH-1:0]    acc_data;
    logic                acc_last;

    rr_picker #(
        .CHANNELS (CHANNELS),
        .IDXW     (SELW)
    ) u_picker (
        .req   (in_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // The output register can take a new beat when empty or being drained.
    assign can_load = !out_valid_q || out_ready;

    // Per-channel slicing, explicit-select match, one-hot candidate and ready.
    // in_ready is gated by rst_n so nothing is accepted while reset is held.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign chan_data[gi]   = in_data[gi*WIDTH +: WIDTH];
            assign sel_hit_vec[gi] = in_valid[gi] && (sel == SELW'(gi));
            assign cand_oh[gi]     = cand_valid && (cand_idx == SELW'(gi));
            assign in_ready[gi]    = rst_n && can_load && cand_oh[gi];
        end
    endgenerate

    // Candidate channel: the locked grant, else the mode's choice. An
    // out-of-range sel matches no channel, so it simply yields no candidate.
    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = '0;
        if (state_q == LOCKED) begin
            cand_valid = 1'b1;
            cand_idx   = grant_q;
        end else if (MODE == MODE_RR) begin
            cand_valid = pick_found;
            cand_idx   = pick_idx;
        end else begin
            cand_valid = |sel_hit_vec;
            cand_idx   = sel;
        end
    end

    // Accept when the single ready channel is also valid.
    assign accept = |(in_valid & in_ready);

    // Beat mux driven by the one-hot candidate.
    always_comb begin
        acc_data = '0;
        acc_last = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cand_oh[i]) begin
                acc_data = chan_data[i];
                acc_last = in_last[i];
            end
        end
    end

    // Next-state: output register load/drain, lock FSM and round-robin pointer.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_chan_d  = out_chan_q;
        busy_d      = busy_q;

        if (accept) begin
            out_data_d  = acc_data;
            out_last_d  = acc_last;
            out_chan_d  = cand_idx;
            out_valid_d = 1'b1;
            if (acc_last) begin
                // Packet complete: release the lock and advance the pointer.
                state_d  = IDLE;
                busy_d   = 1'b0;
                rr_ptr_d = SELW'(wrap_inc(int'(cand_idx), CHANNELS));
            end else begin
                // Packet continues: hold this channel until its last beat.
                state_d = LOCKED;
                grant_d = cand_idx;
                busy_d  = 1'b1;
            end
        end else if (out_ready) begin
            // Sink took the beat and nothing replaces it.
            out_valid_d = 1'b0;
        end
    end

    // State register with asynchronous reset; reset drops any lock and held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_chan_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_chan_q  <= out_chan_d;
            busy_q      <= busy_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_chan  = out_chan_q;
    assign busy      = busy_q;

    // At most one channel is ever offered a ready.
    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));

    // While locked, only the granted channel may be offered a ready.
    assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == LOCKED) |-> ((in_ready & ~(CHANNELS'(1) << grant_q)) == '0));

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: one explicit-select and one round-robin
// instance share stimulus; mode_sel routes valids to the instance under test.
module tb_stream_mux_rr;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int SW = 2;

    typedef struct packed {
        logic [W-1:0]  data;
        logic          last;
        logic [SW-1:0] chan;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [C*W-1:0] in_data;
    logic [C-1:0]   in_valid;
    logic [C-1:0]   in_last;
    logic [SW-1:0]  sel;
    logic           out_ready;
    logic           mode_sel;

    logic [C-1:0]  vld0, vld1, rdy0, rdy1;
    logic [W-1:0]  od0, od1;
    logic          ov0, ov1, ol0, ol1, busy0, busy1;
    logic [SW-1:0] oc0, oc1;

    logic [C-1:0]  cur_rdy;
    logic [W-1:0]  cur_od;
    logic          cur_ov, cur_ol, cur_busy;
    logic [SW-1:0] cur_oc;

    beat_t exp_q[$];
    beat_t mon_exp;
    int    n_checks = 0;
    int    n_err    = 0;

    always #5 clk = ~clk;

    assign vld0 = mode_sel ? '0 : in_valid;
    assign vld1 = mode_sel ? in_valid : '0;

    assign cur_rdy  = mode_sel ? rdy1  : rdy0;
    assign cur_od   = mode_sel ? od1   : od0;
    assign cur_ov   = mode_sel ? ov1   : ov0;
    assign cur_ol   = mode_sel ? ol1   : ol0;
    assign cur_oc   = mode_sel ? oc1   : oc0;
    assign cur_busy = mode_sel ? busy1 : busy0;

    stream_mux_rr #(.WIDTH(W), .CHANNELS(C), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(vld0),
        .in_last(in_last), .in_ready(rdy0), .sel(sel), .out_data(od0),
        .out_valid(ov0), .out_last(ol0), .out_chan(oc0),
        .out_ready(out_ready), .busy(busy0)
    );

    stream_mux_rr #(.WIDTH(W), .CHANNELS(C), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(vld1),
        .in_last(in_last), .in_ready(rdy1), .sel(sel), .out_data(od1),
        .out_valid(ov1), .out_last(ol1), .out_chan(oc1),
        .out_ready(out_ready), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input logic l, input logic [SW-1:0] c);
        beat_t b;
        b.data = d;
        b.last = l;
        b.chan = c;
        exp_q.push_back(b);
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] d, input logic l);
        in_data[ch*W +: W] = d;
        in_last[ch]        = l;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present a lone beat on one channel and hold it until accepted (bounded).
    task automatic send_beat(input int ch, input logic [W-1:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        set_ch(ch, d, l);
        in_valid = 4'(1) << ch;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (cur_rdy[ch]) ok = 1'b1;
            next_cycle();
        end
        in_valid = '0;
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL send_beat ch%0d: got no in_ready in 20 cycles, required accept", ch);
        end
    endtask

    // Monitor: every beat the sink takes is compared against the queue head.
    always @(negedge clk) begin
        if (rst_n && cur_ov && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL monitor: got beat data 0x%0h chan %0d, required no beat", cur_od, cur_oc);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_data", 32'(cur_od), 32'(mon_exp.data));
                check("out_chan", 32'(cur_oc), 32'(mon_exp.chan));
                check("out_last", 32'(cur_ol), 32'(mon_exp.last));
                $display("beat data=0x%02h chan=%0d last=%0d", cur_od, cur_oc, cur_ol);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: valid on the selected channel must still see no ready.
        rst_n     = 1'b0;
        in_data   = '0;
        in_last   = '0;
        in_valid  = 4'b0100;
        sel       = 2'd2;
        out_ready = 1'b0;
        mode_sel  = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset out_valid", 32'(cur_ov), 0);
        check("reset out_data", 32'(cur_od), 0);
        check("reset out_chan", 32'(cur_oc), 0);
        check("reset busy", 32'(cur_busy), 0);
        check("reset in_ready", 32'(cur_rdy), 0);
        next_cycle();
        rst_n    = 1'b1;
        in_valid = '0;
        next_cycle();

        // Explicit select, single-beat packet on ch2.
        out_ready = 1'b1;
        sel       = 2'd2;
        push(8'hA5, 1'b1, 2'd2);
        send_beat(2, 8'hA5, 1'b1);
        @(negedge clk);
        check("A busy", 32'(cur_busy), 0);
        check("A out_valid", 32'(cur_ov), 1);
        next_cycle();

        // Lock: 3-beat packet on ch1, sel moves to 3 mid-packet.
        sel = 2'd1;
        set_ch(1, 8'h11, 1'b0);
        set_ch(3, 8'h33, 1'b1);
        in_valid = 4'b1010;
        push(8'h11, 1'b0, 2'd1);
        push(8'h12, 1'b0, 2'd1);
        push(8'h13, 1'b1, 2'd1);
        push(8'h33, 1'b1, 2'd3);
        @(negedge clk);
        check("B rdy beat1", 32'(cur_rdy), 32'h2);
        next_cycle();
        set_ch(1, 8'h12, 1'b0);
        sel = 2'd3;
        @(negedge clk);
        check("B busy beat2", 32'(cur_busy), 1);
        check("B rdy beat2", 32'(cur_rdy), 32'h2);
        next_cycle();
        set_ch(1, 8'h13, 1'b1);
        @(negedge clk);
        check("B busy beat3", 32'(cur_busy), 1);
        check("B rdy beat3", 32'(cur_rdy), 32'h2);
        next_cycle();
        in_valid = 4'b1000;
        @(negedge clk);
        check("B busy after", 32'(cur_busy), 0);
        check("B rdy ch3", 32'(cur_rdy), 32'h8);
        next_cycle();
        in_valid = '0;
        next_cycle();

        // Back-pressure: beat 0x40 held for 5 cycles, then 0x41 loads with no bubble.
        sel = 2'd0;
        set_ch(0, 8'h40, 1'b1);
        in_valid = 4'b0001;
        push(8'h40, 1'b1, 2'd0);
        push(8'h41, 1'b1, 2'd0);
        next_cycle();
        set_ch(0, 8'h41, 1'b1);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("C hold data", 32'(cur_od), 32'h40);
            check("C hold valid", 32'(cur_ov), 1);
            check("C hold rdy", 32'(cur_rdy), 0);
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("C release rdy", 32'(cur_rdy), 32'h1);
        next_cycle();
        in_valid = '0;
        @(negedge clk);
        check("C no bubble valid", 32'(cur_ov), 1);
        check("C no bubble data", 32'(cur_od), 32'h41);
        next_cycle();
        next_cycle();

        // Round-robin fairness: all channels valid, one beat per cycle.
        mode_sel = 1'b1;
        for (int i = 0; i < C; i++) set_ch(i, 8'(8'hC0 + i), 1'b1);
        for (int k = 0; k < 8; k++) push(8'(8'hC0 + (k % 4)), 1'b1, 2'(k % 4));
        in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("D rr rdy", 32'(cur_rdy), 32'(4'b0001 << (k % 4)));
            if (k > 0) check("D rr valid", 32'(cur_ov), 1);
            next_cycle();
        end
        in_valid = '0;
        next_cycle();

        // Wrap and skip: ptr to 3 via ch2, then only ch1 valid; ptr becomes 2.
        push(8'h22, 1'b1, 2'd2);
        send_beat(2, 8'h22, 1'b1);
        set_ch(1, 8'h21, 1'b1);
        in_valid = 4'b0010;
        push(8'h21, 1'b1, 2'd1);
        @(negedge clk);
        check("E skip rdy", 32'(cur_rdy), 32'h2);
        next_cycle();
        for (int i = 0; i < C; i++) set_ch(i, 8'(8'hC0 + i), 1'b1);
        in_valid = 4'b1111;
        push(8'hC2, 1'b1, 2'd2);
        @(negedge clk);
        check("E ptr rdy", 32'(cur_rdy), 32'h4);
        next_cycle();
        in_valid = '0;
        next_cycle();

        // Reset mid-packet on ch0, then a fresh 2-beat packet on ch2.
        set_ch(0, 8'h50, 1'b0);
        in_valid = 4'b0001;
        push(8'h50, 1'b0, 2'd0);
        @(negedge clk);
        check("F rdy beat1", 32'(cur_rdy), 32'h1);
        next_cycle();
        set_ch(0, 8'h51, 1'b0);
        @(negedge clk);
        check("F busy", 32'(cur_busy), 1);
        next_cycle();
        set_ch(0, 8'h52, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("F rst out_valid", 32'(cur_ov), 0);
        check("F rst busy", 32'(cur_busy), 0);
        check("F rst in_ready", 32'(cur_rdy), 0);
        check("F rst out_data", 32'(cur_od), 0);
        next_cycle();
        in_valid = '0;
        rst_n    = 1'b1;
        next_cycle();
        set_ch(2, 8'h61, 1'b0);
        in_valid = 4'b0100;
        push(8'h61, 1'b0, 2'd2);
        push(8'h62, 1'b1, 2'd2);
        @(negedge clk);
        check("F new rdy", 32'(cur_rdy), 32'h4);
        next_cycle();
        set_ch(2, 8'h62, 1'b1);
        @(negedge clk);
        check("F new busy", 32'(cur_busy), 1);
        check("F new rdy2", 32'(cur_rdy), 32'h4);
        next_cycle();
        in_valid = '0;
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N-channel, W-bit packet multiplexer with valid/ready handshaking and a registered output. It has two selection modes: explicit select, or round-robin arbitration. The grant is locked from the first beat of a packet through its last beat. It replaces ad-hoc 2:1 muxes wherever several streaming sources share one sink.

Parameters:
WIDTH, 8, data bits per beat
CHANNELS, 4, number of input channels (>=2)
MODE, 0, 0 = explicit select via sel; 1 = round-robin among valid channels
SELW, $clog2(CHANNELS), width of sel and out_chan

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  CHANNELS  per-channel beat valid
in_last  input  CHANNELS  per-channel end-of-packet marker
in_ready  output  CHANNELS  per-channel accept (combinational)
sel  input  SELW  requested channel, MODE 0 only; ignored in MODE 1
out_data  output  WIDTH  registered beat
out_valid  output  1  registered valid
out_last  output  1  registered last
out_chan  output  SELW  channel the current out beat came from
out_ready  input  1  sink accept
busy  output  1  high while a packet grant is locked

Behaviour:
- Reset (rst_n low, async): out_data=0, out_valid=0, out_last=0, out_chan=0, busy=0, state=IDLE, rr_ptr=0. in_ready is forced to all-0 while rst_n is low.
- can_load = !out_valid || out_ready. This gives one-cycle latency and a throughput of 1 beat/cycle.
- Channel choice (cand) in IDLE:
  - MODE 0: cand=sel if sel<CHANNELS and in_valid[sel]; otherwise none.
  - MODE 1: first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... mod CHANNELS; otherwise none.
- Channel choice in LOCKED: cand=grant, regardless of sel or other valids.
- in_ready[i] = can_load && cand==i && state/cand valid. At most one bit is ever set. in_ready may depend on in_valid and out_ready combinationally.
- Accept = in_valid[cand] && in_ready[cand]. On accept: out_data, out_last and out_chan are loaded from cand, and out_valid<=1.
- No accept and out_ready: out_valid<=0. out_data holds its value.
- No accept and !out_ready: all outputs hold.
- FSM states: IDLE, LOCKED.
  - IDLE -> LOCKED on accept with in_last=0. Set grant=cand and busy=1.
  - IDLE stays IDLE on accept with in_last=1 (single-beat packet).
  - LOCKED -> IDLE on accept with in_last=1. busy=0 from the next cycle.
- Round-robin pointer: on every accept with in_last=1, rr_ptr <= (cand+1) mod CHANNELS, with wrap at CHANNELS-1 -> 0. Updated in both modes; only used in MODE 1.
- MODE 0 with sel out of range (CHANNELS not a power of 2): no grant, all in_ready=0, no hang.
- A sel change while LOCKED is ignored. The new sel takes effect at the next packet start.
- Back-pressure while LOCKED: the grant holds indefinitely. Other channels get no in_ready.
- Simultaneous out_ready and accept: the output is replaced with the new beat in the same edge, with no bubble.
- Reset mid-packet: the lock is dropped and the held output beat is discarded (out_valid=0). The source must restart its packet.
- No combinational path from in_data to out_data.

Decomposition:
- Shared package stream_mux_pkg holds:
  - state enum typedef (IDLE, LOCKED);
  - MODE_SEL=0 and MODE_RR=1 constants.
- One sub-module, rr_picker (CHANNELS parameter): inputs req vector and ptr; outputs found and idx. Purely combinational rotate-and-priority-encode.
- The top level holds the FSM, rr_ptr, grant and output register.

Test Plan:
- MODE0, CHANNELS=4, WIDTH=8. sel=2; in_valid=0100; in_data ch2=0xA5; in_last=1; out_ready=1 -> next cycle out_data=0xA5, out_valid=1, out_chan=2, out_last=1, busy=0.
- MODE0 lock. sel=1; ch1 sends a 3-beat packet 0x11, 0x12, 0x13 (last on 0x13); sel switches to 3 after beat 1 -> all three beats emerge on consecutive cycles with out_chan=1 and busy=1 through beat 3; ch3 is served only after that.
- MODE1 fairness. All 4 channels hold valid single-beat packets continuously; out_ready=1 -> out_chan sequence 0,1,2,3,0,1, ... with one beat per cycle.
- Back-pressure. out_ready=0 for 5 cycles with a valid beat held -> out_data and out_valid are stable and all in_ready=0. On out_ready=1, the next beat loads in the same cycle with no bubble.
- Wrap and skip. MODE1, rr_ptr=3, valid only on ch1 -> ch1 is granted and rr_ptr becomes 2 after its last beat.
- Reset mid-packet. Deassert rst_n during beat 2 of a 4-beat packet -> out_valid=0, busy=0 and in_ready=0 immediately (async). After release, a new packet from another channel is granted normally.
